// File: rtl/nexus_bucket_dequeue_ctrl.sv
// nexus_bucket_dequeue_ctrl: per-bucket occupancy counters, bitset set/clear
// pulse generation and a three-state pop sequencer (IDLE -> UPDATE -> RESP).
// Optional build macro: NEXUS_DEQ_STATS_EN adds o_total_occ, the running sum
// of all bucket counters.
module nexus_bucket_dequeue_ctrl #(
    parameter int unsigned BUCKETS = 256,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned IDX_W   = $clog2(BUCKETS)
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_push_valid,
    input  logic [IDX_W-1:0] i_push_bucket,
    output logic             o_push_ready,
    output logic             o_overflow,
    input  logic             i_pop_req,
    output logic             o_pop_empty,
    output logic             o_pop_valid,
    output logic [IDX_W-1:0] o_pop_bucket,
    input  logic             i_pop_ready,
    output logic             o_bs_set_valid,
    output logic             o_bs_clear_valid,
    output logic [IDX_W-1:0] o_bs_bucket_idx,
    input  logic             i_bs_valid,
    input  logic [IDX_W-1:0] i_bs_best_idx
`ifdef NEXUS_DEQ_STATS_EN
    ,
    output logic [IDX_W+CNT_W-1:0] o_total_occ
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q [BUCKETS];
    logic [IDX_W-1:0] pop_idx_q;
    logic [IDX_W-1:0] pop_idx_d;
    logic [CNT_W-1:0] push_cnt_c;
    logic [CNT_W-1:0] pop_cnt_c;
    logic             push_acc_c;
    logic             set_d;
    logic             ovf_d;
    logic             clear_d;
    logic             dec_d;
    logic             empty_d;
    logic [IDX_W-1:0] idx_d;

    // State register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q   <= ST_IDLE;
            pop_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pop_idx_q <= pop_idx_d;
        end
    end

    // Next-state and next-output decode; UPDATE is the only state that
    // touches the popped counter, and pushes are blocked there.
    always_comb begin
        state_d    = state_q;
        pop_idx_d  = pop_idx_q;
        push_cnt_c = cnt_q[i_push_bucket];
        pop_cnt_c  = cnt_q[pop_idx_q];
        push_acc_c = i_push_valid && o_push_ready;
        set_d      = push_acc_c && (push_cnt_c != CNT_MAX);
        ovf_d      = push_acc_c && (push_cnt_c == CNT_MAX);
        clear_d    = 1'b0;
        dec_d      = 1'b0;
        empty_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_pop_req) begin
                    if (i_bs_valid) begin
                        pop_idx_d = i_bs_best_idx;
                        state_d   = ST_UPDATE;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                dec_d   = (pop_cnt_c != '0);
                clear_d = (pop_cnt_c == CNT_W'(1));
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (i_pop_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        idx_d = set_d ? i_push_bucket : (clear_d ? pop_idx_q : o_bs_bucket_idx);
    end

    // Registered outputs
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_push_ready     <= 1'b0;
            o_overflow       <= 1'b0;
            o_pop_empty      <= 1'b0;
            o_pop_valid      <= 1'b0;
            o_bs_set_valid   <= 1'b0;
            o_bs_clear_valid <= 1'b0;
            o_bs_bucket_idx  <= '0;
        end else begin
            o_push_ready     <= (state_d != ST_UPDATE);
            o_overflow       <= ovf_d;
            o_pop_empty      <= empty_d;
            o_pop_valid      <= (state_d == ST_RESP);
            o_bs_set_valid   <= set_d;
            o_bs_clear_valid <= clear_d;
            o_bs_bucket_idx  <= idx_d;
        end
    end

    assign o_pop_bucket = pop_idx_q;

    // Occupancy counters: increment on a non-saturated push, decrement in UPDATE
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            for (int unsigned i = 0; i < BUCKETS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (set_d) begin
            cnt_q[i_push_bucket] <= push_cnt_c + CNT_W'(1);
        end else if (dec_d) begin
            cnt_q[pop_idx_q] <= pop_cnt_c - CNT_W'(1);
        end
    end

    // A pop of an empty counter means the bitset and counters disagree
    always_ff @(posedge i_clk) begin
        if (i_arst_n && (state_q == ST_UPDATE)) begin
            assert (pop_cnt_c != '0)
                else $error("decrement of empty bucket %0d", pop_idx_q);
        end
    end

`ifdef NEXUS_DEQ_STATS_EN
    localparam int unsigned TOT_W = IDX_W + CNT_W;

    logic [TOT_W-1:0] total_q;

    // Running sum of all counters
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            total_q <= '0;
        end else begin
            case ({set_d, dec_d})
                2'b10:   total_q <= total_q + TOT_W'(1);
                2'b01:   total_q <= total_q - TOT_W'(1);
                default: total_q <= total_q;
            endcase
        end
    end

    assign o_total_occ = total_q;
`endif

endmodule

// File: doc/nexus_bucket_dequeue_ctrl.md
Name: nexus_bucket_dequeue_ctrl

Overview:
Occupancy-tracking controller that sits between the PIFO enqueue/dequeue ports and the two-level macro bitset.
- Keeps a per-bucket element counter.
- Drives bitset set-pulses on push and clear-pulses when a bucket drains to zero.
- Serves pop requests by sampling the bitset's best-bucket output through a small FSM and returning the chosen bucket on a valid/ready response.

Parameters:
BUCKETS, 256, number of buckets; must equal the bitset's bucket count.
CNT_W, 8, width of each per-bucket occupancy counter; max occupancy is 2^CNT_W-1.
IDX_W, $clog2(BUCKETS), bucket index width (derived; do not override).

Ports:
i_clk  in  1  clock; all state changes on its rising edge.
i_arst_n  in  1  reset; asynchronous, active-low.
i_push_valid  in  1  push request.
i_push_bucket  in  IDX_W  bucket to increment.
o_push_ready  out  1  push accepted when i_push_valid && o_push_ready.
o_overflow  out  1  1-cycle pulse: accepted push hit a saturated counter and was dropped.
i_pop_req  in  1  pop request, sampled only in IDLE.
o_pop_empty  out  1  1-cycle pulse: pop requested while the bitset reports empty.
o_pop_valid  out  1  pop response valid.
o_pop_bucket  out  IDX_W  bucket popped.
i_pop_ready  in  1  consumer accepts the response.
o_bs_set_valid  out  1  to bitset: mark bucket non-empty.
o_bs_clear_valid  out  1  to bitset: mark bucket empty.
o_bs_bucket_idx  out  IDX_W  bucket index for the set/clear pulse.
i_bs_valid  in  1  from bitset: any bucket non-empty.
i_bs_best_idx  in  IDX_W  from bitset: lowest-index non-empty bucket (combinational).

Behaviour:
- Reset (async assert, sync release internally not required):
  - All counters = 0; FSM = IDLE.
  - All outputs = 0, except o_push_ready = 1 on the first clock after reset release.
  - Reset mid-operation aborts any pop in flight and produces no response.
- FSM states:
  - IDLE:
    - i_pop_req && i_bs_valid: capture i_bs_best_idx into pop_idx, go to UPDATE.
    - i_pop_req && !i_bs_valid: pulse o_pop_empty next cycle, stay in IDLE.
  - UPDATE:
    - Decrement cnt[pop_idx].
    - If the old value was 1, pulse o_bs_clear_valid with o_bs_bucket_idx = pop_idx.
    - Go to RESP.
  - RESP:
    - o_pop_valid = 1 and o_pop_bucket = pop_idx, held stable until i_pop_ready.
    - On handshake, go to IDLE; o_pop_valid drops the next cycle.
- Pop latency: request in cycle N -> o_pop_valid asserted in cycle N+2 (registered). Back-to-back pops are spaced at minimum 3 cycles.
- Push:
  - o_push_ready = 1 in IDLE and RESP, 0 in UPDATE. This guarantees set and clear pulses never coincide.
  - Accepted push with cnt < max: cnt += 1 and pulse o_bs_set_valid next cycle with o_bs_bucket_idx = i_push_bucket.
  - The set pulse is issued on every accepted push, not only on the 0->1 transition.
  - Accepted push with cnt == 2^CNT_W-1: counter unchanged, no set pulse, o_overflow pulses.
- Simultaneous push and pop in IDLE:
  - Both are accepted. The pop samples the pre-push bitset state.
  - If both target the same bucket, the increment lands before the UPDATE decrement, so the count stays consistent and no clear is issued unless the result is 0.
- Decrement of a zero counter is unreachable by construction. Implementation must assert (simulation only) and leave the counter at 0.
- o_bs_bucket_idx holds its last value when neither pulse is active.

Optional Feature:
NEXUS_DEQ_STATS_EN:
- Defined: adds output o_total_occ (IDX_W+CNT_W bits), a registered sum of all counters.
  - Increments on each non-dropped push and decrements in UPDATE; net 0 when both happen in the same cycle.
  - Resets to 0.
- Undefined: the port and its logic are absent.

Test Plan:
- Reset release, i_pop_req=1 with i_bs_valid=0 -> o_pop_empty pulses once, o_pop_valid stays 0, no bitset pulses.
- Push bucket 37 twice, then pop (bitset model returns 37) -> two set pulses idx 37; first pop gives o_pop_bucket=37 with no clear; second pop gives clear pulse idx 37 in UPDATE.
- Push buckets 200 then 5, pop with i_pop_ready held 0 for 4 cycles -> o_pop_valid=1, o_pop_bucket=5 held stable 4 cycles; drops 1 cycle after i_pop_ready=1.
- Push in the UPDATE cycle -> o_push_ready=0 that cycle, push retried and accepted next cycle; set and clear pulses never overlap.
- CNT_W=2: four pushes to bucket 9 -> third push reaches cnt=3; fourth push pulses o_overflow and issues no set pulse; three pops drain the bucket with a clear on the third.
- Assert i_arst_n=0 during RESP -> o_pop_valid=0 immediately, counters 0; a post-reset pop reports empty.
